// File: rtl/deadtime_gen.sv
// ============================================================================
//  Module      : deadtime_gen
//  Description : Multi-phase dead-time inserter for a half-bridge power stage.
//                Any change on a phase's gate requests forces that phase low
//                for a programmable dead window of dt_cycles+1 clocks. A
//                shoot-through request sets a sticky fault that forces every
//                phase low until it is cleared.
//  Revision    : 1.0 - initial multi-phase release
// ============================================================================
`default_nettype none

module deadtime_gen #(
  parameter int NUM_PH = 3,
  parameter int DT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DT_W-1:0]   dt_cycles,
  input  logic [NUM_PH-1:0] high_in,
  input  logic [NUM_PH-1:0] low_in,
  input  logic              fault_clr,
  output logic [NUM_PH-1:0] high_out,
  output logic [NUM_PH-1:0] low_out,
  output logic [NUM_PH-1:0] dt_active,
  output logic              fault
);

  typedef enum logic [0:0] {
    ST_DEAD  = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  logic any_illegal;
  logic force_dead;
  logic fault_q;
  logic fault_d;

  // Any phase requesting both switches at once is a shoot-through request.
  assign any_illegal = |(high_in & low_in);

  // Fault sets on an enabled illegal request; it only clears on fault_clr
  // when no illegal request is present, so a simultaneous new illegal
  // request always wins over the clear.
  always_comb begin
    fault_d = fault_q;
    if (en && any_illegal) begin
      fault_d = 1'b1;
    end else if (fault_clr && !any_illegal) begin
      fault_d = 1'b0;
    end
  end

  // Using the next fault value lets the setting edge also blank the outputs,
  // so both switches of a phase can never be driven together.
  assign force_dead = fault_d | ~en;

  // Sticky fault register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;

  for (genvar i = 0; i < NUM_PH; i++) begin : g_phase
    state_t          state_q, state_d;
    logic [DT_W-1:0] cnt_q, cnt_d;
    logic            hi_q, hi_d;
    logic            lo_q, lo_d;
    logic            prev_hi_q, prev_lo_q;
    logic            changed;

    assign changed = (high_in[i] != prev_hi_q) | (low_in[i] != prev_lo_q);

    // Next-state: forced dead, restart on change, count out the window,
    // then follow the requests while driving.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = 1'b0;
      lo_d    = 1'b0;
      if (force_dead || changed) begin
        state_d = ST_DEAD;
        cnt_d   = '0;
      end else if (state_q == ST_DEAD) begin
        // The >= compare ends the window at once if dt_cycles is lowered
        // below the running count, so the counter never wraps.
        if (cnt_q < dt_cycles) begin
          cnt_d = cnt_q + DT_W'(1);
        end else begin
          state_d = ST_DRIVE;
          hi_d    = high_in[i];
          lo_d    = low_in[i];
        end
      end else begin
        hi_d = high_in[i];
        lo_d = low_in[i];
      end
    end

    // Phase state, counter, output and input-history registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= ST_DEAD;
        cnt_q     <= '0;
        hi_q      <= 1'b0;
        lo_q      <= 1'b0;
        prev_hi_q <= 1'b0;
        prev_lo_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        hi_q      <= hi_d;
        lo_q      <= lo_d;
        prev_hi_q <= high_in[i];
        prev_lo_q <= low_in[i];
      end
    end

    assign high_out[i]  = hi_q;
    assign low_out[i]   = lo_q;
    assign dt_active[i] = (state_q == ST_DEAD);
  end

endmodule

`default_nettype wire

// File: tb/tb_deadtime_gen.sv
// ============================================================================
//  Module      : tb_deadtime_gen
//  Description : Directed scoreboard bench for deadtime_gen. Stimulus pushes
//                expected output snapshots tagged with the clock edge they
//                belong to; a monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_deadtime_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] dt_cycles;
  logic [2:0] high_in;
  logic [2:0] low_in;
  logic       fault_clr;
  logic [2:0] high_out;
  logic [2:0] low_out;
  logic [2:0] dt_active;
  logic       fault;

  deadtime_gen #(.NUM_PH(3), .DT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .dt_cycles (dt_cycles),
    .high_in   (high_in),
    .low_in    (low_in),
    .fault_clr (fault_clr),
    .high_out  (high_out),
    .low_out   (low_out),
    .dt_active (dt_active),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    logic [2:0] hi;
    logic [2:0] lo;
    logic [2:0] dta;
    logic       flt;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   done = 1'b0;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int at, input logic [2:0] h, input logic [2:0] l,
                           input logic [2:0] d, input logic f, input string nm);
    exp_t e;
    e.at = at; e.hi = h; e.lo = l; e.dta = d; e.flt = f; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Monitor: compares due snapshots, checks switch exclusivity, and closes
  // the run once stimulus is finished.
  always @(negedge clk) begin
    checks++;
    if ((high_out & low_out) != 3'b000) begin
      failures++;
      $display("FAIL exclusive cyc=%0d high_out=%b low_out=%b required no common bit",
               cyc, high_out, low_out);
    end
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      mon_e = sb.pop_front();
      checks++;
      if (mon_e.at < cyc) begin
        failures++;
        $display("FAIL %s missed check at cyc=%0d (now %0d)", mon_e.name, mon_e.at, cyc);
      end else if (high_out !== mon_e.hi || low_out !== mon_e.lo ||
                   dt_active !== mon_e.dta || fault !== mon_e.flt) begin
        failures++;
        $display("FAIL %s cyc=%0d got hi=%b lo=%b dta=%b flt=%b required hi=%b lo=%b dta=%b flt=%b",
                 mon_e.name, cyc, high_out, low_out, dt_active, fault,
                 mon_e.hi, mon_e.lo, mon_e.dta, mon_e.flt);
      end
    end
    if (done) begin
      while (sb.size() > 0) begin
        mon_e = sb.pop_front();
        checks++;
        failures++;
        $display("FAIL %s never checked (due cyc=%0d)", mon_e.name, mon_e.at);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int base;
    rst_n = 1'b0; en = 1'b1; dt_cycles = 8'd10;
    high_in = 3'b001; low_in = 3'b110; fault_clr = 1'b0;

    // Reset state, then a full window (first edge sees inputs != zeroed history).
    tick(3);
    expect_at(cyc, 3'b000, 3'b000, 3'b111, 1'b0, "reset_state");
    rst_n = 1'b1;
    base = cyc;
    expect_at(base + 11, 3'b000, 3'b000, 3'b111, 1'b0, "startup_last_dead");
    expect_at(base + 12, 3'b001, 3'b110, 3'b000, 1'b0, "startup_drive");
    tick(12);

    // Phase 0 hi->lo; phases 1 and 2 keep driving low.
    k = cyc + 1;
    high_in = 3'b000; low_in = 3'b111;
    expect_at(k,      3'b000, 3'b110, 3'b001, 1'b0, "ph0_toggle_dead");
    expect_at(k + 10, 3'b000, 3'b110, 3'b001, 1'b0, "ph0_toggle_last_dead");
    expect_at(k + 11, 3'b000, 3'b111, 3'b000, 1'b0, "ph0_toggle_drive");
    tick(12);

    // Re-toggle five edges into the window restarts it.
    k = cyc + 1;
    high_in = 3'b001; low_in = 3'b110;
    expect_at(k + 4,  3'b000, 3'b110, 3'b001, 1'b0, "retoggle_mid");
    expect_at(k + 15, 3'b000, 3'b110, 3'b001, 1'b0, "retoggle_last_dead");
    expect_at(k + 16, 3'b000, 3'b111, 3'b000, 1'b0, "retoggle_drive");
    tick(5);
    high_in = 3'b000; low_in = 3'b111;
    tick(12);

    // Shoot-through on phase 1, clear ignored while illegal, then cleared.
    k = cyc + 1;
    high_in = 3'b010; low_in = 3'b111;
    expect_at(k,      3'b000, 3'b000, 3'b111, 1'b1, "fault_set");
    expect_at(k + 1,  3'b000, 3'b000, 3'b111, 1'b1, "fault_clr_ignored");
    expect_at(k + 2,  3'b000, 3'b000, 3'b111, 1'b1, "fault_sticky");
    expect_at(k + 3,  3'b000, 3'b000, 3'b111, 1'b0, "fault_cleared");
    expect_at(k + 12, 3'b000, 3'b000, 3'b111, 1'b0, "fault_last_dead");
    expect_at(k + 13, 3'b000, 3'b111, 3'b000, 1'b0, "fault_drive");
    tick(1);
    fault_clr = 1'b1;
    tick(1);
    high_in = 3'b000; fault_clr = 1'b0;
    tick(1);
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    tick(10);

    // dt_cycles = 0 gives exactly one dead cycle.
    k = cyc + 1;
    dt_cycles = 8'd0; high_in = 3'b100; low_in = 3'b011;
    expect_at(k,     3'b000, 3'b011, 3'b100, 1'b0, "dt0_dead");
    expect_at(k + 1, 3'b100, 3'b011, 3'b000, 1'b0, "dt0_drive");
    tick(2);

    // Lowering dt_cycles 200 -> 5 at count 50 ends the window next edge.
    k = cyc + 1;
    dt_cycles = 8'd200; high_in = 3'b000; low_in = 3'b111;
    expect_at(k + 50, 3'b000, 3'b011, 3'b100, 1'b0, "dtlower_still_dead");
    expect_at(k + 51, 3'b000, 3'b111, 3'b000, 1'b0, "dtlower_drive");
    tick(51);
    dt_cycles = 8'd5;
    tick(1);

    // Enable dropped mid-drive, then restored: dt_cycles=5 window.
    k = cyc + 1;
    en = 1'b0;
    expect_at(k,     3'b000, 3'b000, 3'b111, 1'b0, "en_low");
    expect_at(k + 5, 3'b000, 3'b000, 3'b111, 1'b0, "en_rise_last_dead");
    expect_at(k + 6, 3'b000, 3'b111, 3'b000, 1'b0, "en_rise_drive");
    tick(1);
    en = 1'b1;
    tick(6);

    // Asynchronous reset in the middle of a phase-0 window.
    k = cyc + 1;
    high_in = 3'b001; low_in = 3'b110;
    expect_at(k + 1, 3'b000, 3'b110, 3'b001, 1'b0, "pre_reset_window");
    tick(2);
    tick(1);
    #1;
    rst_n = 1'b0;
    dt_cycles = 8'd10;
    expect_at(cyc, 3'b000, 3'b000, 3'b111, 1'b0, "async_reset");
    tick(1);
    rst_n = 1'b1;
    base = cyc;
    expect_at(base + 11, 3'b000, 3'b000, 3'b111, 1'b0, "post_reset_last_dead");
    expect_at(base + 12, 3'b001, 3'b110, 3'b000, 1'b0, "post_reset_drive");
    tick(12);

    tick(2);
    done = 1'b1;
  end

endmodule

`default_nettype wire
